cnt_ctrl: RTL and testbench

Sequencing controller for the team's clear-able up-counter datapath. It owns a W-bit count register and decides when it starts, pauses, stops and wraps. It supports one-shot and periodic runs against a programmable terminal count and reports progress with a busy level and one-cycle `tick`/`done` pulses. It sits between software-style control strobes and any logic that needs a timed event.

---
 rtl/cnt_ctrl.sv | 130 +++++++++++++
 tb/tb_cnt_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_ctrl.sv
// cnt_ctrl: start/stop/hold sequencer for a W-bit terminal-count counter.
// Optional prescaler is enabled by defining CNT_CTRL_PRESCALE_EN.
module cnt_ctrl #(
   parameter int W     = 4,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic             mode,
   input  logic [W-1:0]     tc_in,
`ifdef CNT_CTRL_PRESCALE_EN
   input  logic [PRE_W-1:0] prescale_in,
`endif
   output logic [W-1:0]     cnt,
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HOLD = 2'b10,
      DONE = 2'b11
   } state_t;

   state_t         state_q;
   logic [W-1:0]   tc_reg;
   logic           mode_reg;
   logic           adv;
   logic           go;
   logic           run_step;

   if (W < 1 || PRE_W < 1) begin : g_bad_param
      $error("cnt_ctrl: W and PRE_W must be at least 1");
   end

   // start acceptance and an unblocked RUN cycle
   assign go       = (state_q == IDLE) && start && !stop;
   assign run_step = (state_q == RUN) && !stop && !hold;

`ifdef CNT_CTRL_PRESCALE_EN
   logic [PRE_W-1:0] pre_reg;
   logic [PRE_W-1:0] pre_cnt;

   assign adv = (pre_cnt == pre_reg);

   // divider: one advance every pre_reg+1 unblocked RUN cycles
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         pre_reg <= '0;
         pre_cnt <= '0;
      end else if (go) begin
         pre_reg <= prescale_in;
         pre_cnt <= '0;
      end else if (stop) begin
         pre_cnt <= '0;
      end else if (run_step) begin
         if (adv) pre_cnt <= '0;
         else     pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end
`else
   assign adv = 1'b1;
`endif

   // sequencer with registered count and pulse outputs
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q  <= IDLE;
         cnt      <= '0;
         tc_reg   <= '0;
         mode_reg <= 1'b0;
         tick     <= 1'b0;
         done     <= 1'b0;
      end else begin
         tick <= 1'b0;
         done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (go) begin
                  tc_reg   <= tc_in;
                  mode_reg <= mode;
                  cnt      <= '0;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  state_q <= IDLE;
                  cnt     <= '0;
               end else if (hold) begin
                  state_q <= HOLD;
               end else if (run_step && adv) begin
                  if (cnt != tc_reg) begin
                     cnt <= cnt + W'(1);
                  end else begin
                     tick <= 1'b1;
                     if (mode_reg) begin
                        cnt <= '0;
                     end else begin
                        done    <= 1'b1;
                        state_q <= DONE;
                     end
                  end
               end
            end
            HOLD: begin
               if (stop) begin
                  state_q <= IDLE;
                  cnt     <= '0;
               end else if (!hold) begin
                  state_q <= RUN;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy  = (state_q == RUN) || (state_q == HOLD);
   assign state = state_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// tb_cnt_ctrl: directed and random stimulus for cnt_ctrl, checked every
// cycle against an advance-count reference model.
module tb_cnt_ctrl;

   logic       clk;
   logic       clr_n;
   logic       start;
   logic       stop;
   logic       hold;
   logic       mode;
   logic [3:0] tc_in;
   logic [3:0] prescale_in;
   logic [3:0] cnt;
   logic       busy;
   logic       tick;
   logic       done;
   logic [1:0] state;

   int n_checks;
   int n_fail;

   // reference model: phase 0 idle, 1 run, 2 hold, 3 done
   int m_ph;
   int m_n;
   int m_sub;
   int m_tc;
   int m_p;
   int m_idle_cnt;
   bit m_per;
   bit m_tick;
   bit m_done;

   cnt_ctrl #(.W(4), .PRE_W(4)) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .start       (start),
      .stop        (stop),
      .hold        (hold),
      .mode        (mode),
      .tc_in       (tc_in),
`ifdef CNT_CTRL_PRESCALE_EN
      .prescale_in (prescale_in),
`endif
      .cnt         (cnt),
      .busy        (busy),
      .tick        (tick),
      .done        (done),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_ph = 0; m_n = 0; m_sub = 0; m_tc = 0; m_p = 0;
      m_idle_cnt = 0; m_per = 0; m_tick = 0; m_done = 0;
   endtask

   function automatic int m_cnt();
      if (m_ph == 0) return m_idle_cnt;
      if (m_per) return m_n % (m_tc + 1);
      return (m_n > m_tc) ? m_tc : m_n;
   endfunction

   task automatic m_step();
      m_tick = 0;
      m_done = 0;
      case (m_ph)
         0: if (start && !stop) begin
            m_ph  = 1;
            m_tc  = int'(tc_in);
            m_per = mode;
`ifdef CNT_CTRL_PRESCALE_EN
            m_p   = int'(prescale_in);
`else
            m_p   = 0;
`endif
            m_n   = 0;
            m_sub = 0;
         end
         1: if (stop) begin
            m_ph = 0;
            m_idle_cnt = 0;
         end else if (hold) begin
            m_ph = 2;
         end else begin
            m_sub++;
            if (m_sub % (m_p + 1) == 0) begin
               m_n++;
               if (m_n % (m_tc + 1) == 0) begin
                  m_tick = 1;
                  if (!m_per) begin
                     m_done = 1;
                     m_ph = 3;
                  end
               end
            end
         end
         2: if (stop) begin
            m_ph = 0;
            m_idle_cnt = 0;
         end else if (!hold) begin
            m_ph = 1;
         end
         default: begin
            m_ph = 0;
            m_idle_cnt = m_tc;
         end
      endcase
   endtask

   task automatic compare();
      check("cnt", 32'(cnt), 32'(m_cnt()));
      check("state", 32'(state), 32'(m_ph));
      check("busy", 32'(busy), 32'(m_ph == 1 || m_ph == 2));
      check("tick", 32'(tick), 32'(m_tick));
      check("done", 32'(done), 32'(m_done));
   endtask

   task automatic cyc();
      @(posedge clk);
      m_step();
      @(negedge clk);
      compare();
   endtask

   task automatic idle_in();
      start = 0; stop = 0; hold = 0; mode = 0; tc_in = 0;
   endtask

   task automatic kick(input logic m, input logic [3:0] tc);
      start = 1; mode = m; tc_in = tc;
      cyc();
      start = 0;
   endtask

   task automatic do_stop();
      stop = 1;
      cyc();
      stop = 0;
   endtask

   int ticks;
   int last_tick;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      idle_in();
      prescale_in = 0;
      clr_n = 0;
      m_reset();
      #1;
      check("rst_cnt", 32'(cnt), 0);
      check("rst_state", 32'(state), 0);
      check("rst_busy", 32'(busy), 0);
      @(negedge clk);
      clr_n = 1;
      cyc();

      // one-shot tc=3
      kick(1'b0, 4'd3);
      check("os_cnt0", 32'(cnt), 0);
      repeat (3) cyc();
      check("os_cnt3", 32'(cnt), 3);
      cyc();
      check("os_tick", 32'(tick), 1);
      check("os_done", 32'(done), 1);
      check("os_cntf", 32'(cnt), 3);
      check("os_state", 32'(state), 3);
      cyc();
      check("os_idle", 32'(state), 0);
      check("os_keep", 32'(cnt), 3);
      check("os_nopulse", 32'(tick | done), 0);

      // periodic tc=2 over 12 cycles
      kick(1'b1, 4'd2);
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (tick) begin
            ticks++;
            check("per_wrap", 32'(cnt), 0);
         end
         check("per_done", 32'(done), 0);
      end
      check("per_ticks", 32'(ticks), 4);
      do_stop();

      // hold at 6, resume, then stop+hold
      kick(1'b1, 4'd15);
      repeat (6) cyc();
      check("h_pre", 32'(cnt), 6);
      hold = 1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("h_frz", 32'(cnt), 6);
         check("h_busy", 32'(busy), 1);
      end
      hold = 0;
      repeat (2) cyc();
      check("h_resume", 32'(cnt), 7);
      stop = 1; hold = 1;
      cyc();
      stop = 0; hold = 0;
      check("sh_state", 32'(state), 0);
      check("sh_cnt", 32'(cnt), 0);
      check("sh_tick", 32'(tick), 0);

      // tc=0 periodic: tick every cycle
      kick(1'b1, 4'd0);
      ticks = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         ticks += int'(tick);
      end
      check("tc0_ticks", 32'(ticks), 5);
      check("tc0_cnt", 32'(cnt), 0);
      do_stop();

      // start+stop in IDLE
      start = 1; stop = 1; tc_in = 4'd7;
      cyc();
      start = 0; stop = 0;
      check("ss_idle", 32'(state), 0);

      // start while running is ignored
      kick(1'b1, 4'd5);
      start = 1; tc_in = 4'd2;
      repeat (3) cyc();
      start = 0;
      repeat (2) cyc();
      check("rs_cnt", 32'(cnt), 5);
      do_stop();

      // tc=15 one-shot, full range
      kick(1'b0, 4'd15);
      repeat (15) cyc();
      check("max_cnt", 32'(cnt), 15);
      cyc();
      check("max_done", 32'(done), 1);
      cyc();

`ifdef CNT_CTRL_PRESCALE_EN
      prescale_in = 4'd1;
      kick(1'b1, 4'd3);
      last_tick = -1;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (tick) begin
            if (last_tick >= 0) check("pre_per", 32'(i - last_tick), 8);
            last_tick = i;
         end
      end
      do_stop();
      prescale_in = 0;
`endif

      // reset mid-run at cnt=5
      kick(1'b0, 4'd9);
      repeat (5) cyc();
      check("mr_pre", 32'(cnt), 5);
      #2;
      clr_n = 0;
      #1;
      check("mr_cnt", 32'(cnt), 0);
      check("mr_state", 32'(state), 0);
      check("mr_busy", 32'(busy), 0);
      check("mr_pulse", 32'(tick | done), 0);
      m_reset();
      @(negedge clk);
      clr_n = 1;
      repeat (3) cyc();

      // random traffic
      for (int i = 0; i < 800; i++) begin
         start = ($urandom_range(0, 9) < 3);
         stop  = ($urandom_range(0, 39) == 0);
         hold  = ($urandom_range(0, 9) < 2);
         mode  = 1'($urandom_range(0, 1));
         tc_in = 4'($urandom_range(0, 15));
`ifdef CNT_CTRL_PRESCALE_EN
         prescale_in = 4'($urandom_range(0, 3));
`endif
         cyc();
      end
      idle_in();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
